mult_div_unit: RTL and testbench

//   Iterative multiply/divide unit in the EX stage, beside the ALU. Consumes the Sign

---
 rtl/mult_div_unit_if.sv | 25 ++
 rtl/mult_div_unit.sv | 158 +++++++++++++++
 tb/tb_mult_div_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the EX stage and the iterative multiply/divide unit.
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic             sign;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, sign, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, sign, a, b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider owning the architectural HI/LO pair.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic            clk,
    input logic            reset,
    mult_div_unit_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDz} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 is_div_q, is_div_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, done_q;
    logic                 commit;

    logic [WIDTH-1:0]     a_abs, b_abs;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH-1:0]     div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   prod_neg;

    assign a_abs = (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_abs = (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_ge    = div_shift >= {1'b0, mcand_q};
    assign div_diff  = div_shift[WIDTH-1:0] - mcand_q;
    assign prod_neg  = -acc_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        is_div_d  = is_div_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        commit    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.flush) begin
                    unique case (bus.op)
                        2'b00: begin
                            mcand_d   = a_abs;
                            acc_d     = {{WIDTH{1'b0}}, b_abs};
                            neg_res_d = bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            neg_rem_d = 1'b0;
                            is_div_d  = 1'b0;
                            cnt_d     = '0;
                            state_d   = StMul;
                        end
                        2'b01: begin
                            is_div_d = 1'b1;
                            cnt_d    = '0;
                            if (bus.b == '0) begin
                                mcand_d = bus.a;
                                state_d = StDz;
                            end else begin
                                mcand_d   = b_abs;
                                acc_d     = {{WIDTH{1'b0}}, a_abs};
                                neg_res_d = bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                                neg_rem_d = bus.sign & bus.a[WIDTH-1];
                                state_d   = StDiv;
                            end
                        end
                        2'b10: hi_d = bus.a;
                        2'b11: lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            StMul: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
            end
            StDiv: begin
                acc_d = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                               : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
            end
            StFix: begin
                if (is_div_q) begin
                    lo_d = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    {hi_d, lo_d} = neg_res_q ? prod_neg : acc_q;
                end
                commit  = 1'b1;
                state_d = StIdle;
            end
            StDz: begin
                hi_d    = mcand_q;
                lo_d    = '1;
                commit  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Abort drops the op entirely, including a commit that would happen this edge
        if (bus.flush && state_q != StIdle) begin
            state_d = StIdle;
            hi_d    = hi_q;
            lo_d    = lo_q;
            commit  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_div_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            is_div_q  <= is_div_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= (state_d != StIdle);
            done_q    <= commit;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: vector table through a scoreboard plus flush/reset/mthi sequences.
module tb_mult_div_unit;
    localparam int unsigned W = 32;

    typedef struct {
        logic [1:0]  op;
        logic        sign;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          busy;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          busy;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [31:0] m_hi, m_lo;
    exp_t sb[$];
    vec_t vecs[11];

    mult_div_unit_if #(.WIDTH(W)) bus ();
    mult_div_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v);
        exp_t e;
        int   busy_cnt;
        bit   seen;
        sb.push_back('{hi: v.hi, lo: v.lo, busy: v.busy});
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = v.op;
        bus.sign  = v.sign;
        bus.a     = v.a;
        bus.b     = v.b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        busy_cnt  = 0;
        seen      = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
            else if (bus.busy) busy_cnt++;
        end
        e = sb.pop_front();
        check("done_seen", 32'(seen), 32'd1);
        check("busy_cycles", 32'(busy_cnt), 32'(e.busy));
        check("busy_at_done", 32'(bus.busy), 32'd0);
        check("hi", bus.hi, e.hi);
        check("lo", bus.lo, e.lo);
        @(negedge clk);
        check("done_pulse", 32'(bus.done), 32'd0);
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    initial begin
        bit   flag;
        vec_t v;
        vecs[0]  = '{2'b00, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
        vecs[1]  = '{2'b00, 1'b1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 33};
        vecs[2]  = '{2'b00, 1'b0, 32'hFFFFFFFD, 32'h00000005, 32'h00000004, 32'hFFFFFFF1, 33};
        vecs[3]  = '{2'b01, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[4]  = '{2'b01, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        vecs[5]  = '{2'b01, 1'b0, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1};
        vecs[6]  = '{2'b01, 1'b0, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 33};
        vecs[7]  = '{2'b00, 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 33};
        vecs[8]  = '{2'b01, 1'b1, 32'h00000011, 32'hFFFFFFFB, 32'h00000002, 32'hFFFFFFFD, 33};
        vecs[9]  = '{2'b01, 1'b0, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 33};
        vecs[10] = '{2'b01, 1'b1, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1};

        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.sign  = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) run_op(vecs[i]);

        // mthi then mtlo: write at the issue edge, no busy, no done
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.a     = 32'h00001234;
        @(posedge clk);
        #1;
        bus.op    = 2'b11;
        bus.a     = 32'h00005678;
        check("mthi_hi", bus.hi, 32'h00001234);
        check("mthi_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("mtlo_lo", bus.lo, 32'h00005678);
        check("mtlo_hi_kept", bus.hi, 32'h00001234);
        @(negedge clk);
        check("mtx_done", 32'(bus.done), 32'd0);
        check("mtx_busy", 32'(bus.busy), 32'd0);
        m_hi = 32'h00001234;
        m_lo = 32'h00005678;

        // flush in idle suppresses a same-cycle mtlo
        @(negedge clk);
        bus.flush = 1'b1;
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.a     = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        check("idle_flush_lo", bus.lo, m_lo);

        // flush at busy cycle 10 with a simultaneous start
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.sign  = 1'b0;
        bus.a     = 32'h00000005;
        bus.b     = 32'h00000007;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        check("flush_busy_before", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        check("flush_busy_after", 32'(bus.busy), 32'd0);
        check("flush_hi", bus.hi, m_hi);
        check("flush_lo", bus.lo, m_lo);
        flag = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) flag = 1'b1;
        end
        check("flush_no_done", 32'(flag), 32'd0);
        check("flush_hi_late", bus.hi, m_hi);

        // asynchronous reset mid-divide
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'h00000064;
        bus.b     = 32'h00000007;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        check("arst_hi", bus.hi, 32'h0);
        check("arst_lo", bus.lo, 32'h0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        v = '{2'b01, 1'b0, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 33};
        run_op(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
